// File: rtl/io_mailbox_pkg.sv
// io_mailbox_pkg: register offsets and bit positions shared by the mailbox files
package io_mailbox_pkg;
  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_COUNT  = 2'd3
  } reg_e;
  localparam int ST_RX_AVAIL = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_FULL  = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_UDF   = 5;
  localparam int ST_IRQ_EN   = 6;
  localparam int CTRL_TX_FLUSH = 0;
  localparam int CTRL_RX_FLUSH = 1;
  localparam int CTRL_IRQ_EN   = 2;
endpackage

// File: rtl/io_mailbox_fifo.sv
// byte_fifo: byte FIFO with flush; head byte reads as 0 while empty
module byte_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  logic [7:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0] count_q, count_d;
  logic do_push, do_pop;
  assign empty = count_q == '0;
  assign full = count_q == CW'(DEPTH);
  assign count = count_q;
  assign dout = empty ? 8'h00 : mem_q[rd_ptr_q];
  always_comb begin
    do_push = push && !full;
    do_pop = pop && !empty;
    wr_ptr_d = flush ? '0 : wr_ptr_q + DEPTH_LOG2'(do_push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + DEPTH_LOG2'(do_pop);
    count_d = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/io_mailbox.sv
// io_mailbox: port-mapped byte mailbox with TX/RX FIFOs, status, flush and irq
module io_mailbox
  import io_mailbox_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] port_addr,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       irq
);
  logic [7:0] off, status, rx_dout;
  logic hit, tx_push, tx_pop, tx_flush, rx_push, rx_pop, rx_flush, rx_rd, st_rd, ctrl_wr;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic [DEPTH_LOG2:0] tx_count, rx_count;
  logic tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d, irq_en_q, irq_en_d;
  reg_e sel;
  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
    .din(wr_data), .dout(tx_data), .count(tx_count), .empty(tx_empty), .full(tx_full)
  );
  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
    .din(rx_data), .dout(rx_dout), .count(rx_count), .empty(rx_empty), .full(rx_full)
  );
  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;
  assign irq = irq_en_q && (!rx_empty || tx_ovf_q || rx_udf_q);
  always_comb begin
    off = port_addr - BASE_ADDR;
    hit = off[7:2] == '0;
    sel = reg_e'(off[1:0]);
    tx_push = wr && hit && sel == REG_DATA;
    ctrl_wr = wr && hit && sel == REG_CTRL;
    rx_rd = rd && hit && sel == REG_DATA;
    st_rd = rd && hit && sel == REG_STATUS;
    tx_pop = tx_valid && tx_ready;
    rx_push = rx_valid && rx_ready;
    rx_pop = rx_rd && !rx_empty;
    tx_flush = ctrl_wr && wr_data[CTRL_TX_FLUSH];
    rx_flush = ctrl_wr && wr_data[CTRL_RX_FLUSH];
    irq_en_d = ctrl_wr ? wr_data[CTRL_IRQ_EN] : irq_en_q;
    // a new set event in the same cycle as a STATUS read keeps the flag set
    tx_ovf_d = (tx_push && tx_full) || (tx_ovf_q && !st_rd);
    rx_udf_d = (rx_rd && rx_empty) || (rx_udf_q && !st_rd);
    status = '0;
    status[ST_RX_AVAIL] = !rx_empty;
    status[ST_RX_FULL] = rx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_TX_FULL] = tx_full;
    status[ST_TX_OVF] = tx_ovf_q;
    status[ST_RX_UDF] = rx_udf_q;
    status[ST_IRQ_EN] = irq_en_q;
    rd_data = !(rd && hit) ? 8'h00 :
              sel == REG_DATA ? rx_dout :
              sel == REG_STATUS ? status :
              sel == REG_CTRL ? {5'b0, irq_en_q, 2'b0} :
              {4'(tx_count), 4'(rx_count)};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_udf_q <= rx_udf_d;
      irq_en_q <= irq_en_d;
    end
  end
endmodule

// File: tb/tb_io_mailbox.sv
// tb_io_mailbox: queue-based reference model feeding a scoreboard checked by a negedge monitor
module tb_io_mailbox;
  localparam int DEPTH = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] port_addr = 8'h00, wr_data = 8'h00, rx_data = 8'h00;
  logic wr = 1'b0, rd = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0;
  logic [7:0] rd_data, tx_data;
  logic tx_valid, rx_ready, irq;
  io_mailbox #(.BASE_ADDR(8'h00), .DEPTH_LOG2(3)) dut (
    .clk(clk), .rst_n(rst_n), .port_addr(port_addr), .wr(wr), .rd(rd), .wr_data(wr_data),
    .rd_data(rd_data), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .irq(irq)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] rd_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       rx_ready;
    logic       irq;
  } exp_t;
  exp_t exp_q[$];
  exp_t me;
  logic [7:0] txq[$], rxq[$];
  bit ovf, udf, ien;
  int checks = 0, errors = 0;
  bit tr_s, rv_s;
  logic [7:0] rxd_s;
  task automatic chk(string name, logic [7:0] act, logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      me = exp_q.pop_front();
      chk("rd_data", rd_data, me.rd_data);
      chk("tx_valid", {7'b0, tx_valid}, {7'b0, me.tx_valid});
      chk("tx_data", tx_data, me.tx_data);
      chk("rx_ready", {7'b0, rx_ready}, {7'b0, me.rx_ready});
      chk("irq", {7'b0, irq}, {7'b0, me.irq});
    end
  end
  task automatic drive(bit r, bit w, bit d, logic [7:0] a, logic [7:0] wd, bit tr, bit rv, logic [7:0] rdx);
    exp_t e;
    bit hit, tx_push, tx_acc, tx_pop, rx_rd, rx_pop, rx_acc, st_rd, cw, ovf_set, udf_set;
    logic [7:0] st;
    @(posedge clk);
    #1;
    rst_n = r; wr = w; rd = d; port_addr = a; wr_data = wd;
    tx_ready = tr; rx_valid = rv; rx_data = rdx;
    if (!r) begin
      txq.delete(); rxq.delete(); ovf = 0; udf = 0; ien = 0;
    end
    hit = a < 8'd4;
    e.tx_valid = txq.size() != 0;
    e.tx_data = e.tx_valid ? txq[0] : 8'h00;
    e.rx_ready = rxq.size() < DEPTH;
    e.irq = ien && (rxq.size() != 0 || ovf || udf);
    st = {1'b0, ien, udf, ovf, txq.size() == DEPTH, txq.size() == 0, rxq.size() == DEPTH, rxq.size() != 0};
    e.rd_data = 8'h00;
    if (d && hit)
      case (a)
        8'd0: e.rd_data = rxq.size() != 0 ? rxq[0] : 8'h00;
        8'd1: e.rd_data = st;
        8'd2: e.rd_data = {5'b0, ien, 2'b0};
        default: e.rd_data = {4'(txq.size()), 4'(rxq.size())};
      endcase
    exp_q.push_back(e);
    if (r) begin
      tx_push = w && a == 8'd0;
      cw = w && a == 8'd2;
      rx_rd = d && a == 8'd0;
      st_rd = d && a == 8'd1;
      tx_pop = e.tx_valid && tr;
      tx_acc = tx_push && txq.size() < DEPTH;
      ovf_set = tx_push && !tx_acc;
      rx_pop = rx_rd && rxq.size() != 0;
      udf_set = rx_rd && !rx_pop;
      rx_acc = rv && rxq.size() < DEPTH;
      if (tx_pop) void'(txq.pop_front());
      if (tx_acc) txq.push_back(wd);
      if (rx_pop) void'(rxq.pop_front());
      if (rx_acc) rxq.push_back(rdx);
      if (cw && wd[0]) txq.delete();
      if (cw && wd[1]) rxq.delete();
      if (cw) ien = wd[2];
      ovf = ovf_set || (ovf && !st_rd);
      udf = udf_set || (udf && !st_rd);
    end
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 8'h00, 8'h00, tr_s, rv_s, rxd_s);
  endtask
  task automatic wreg(logic [7:0] a, logic [7:0] d);
    drive(1, 1, 0, a, d, tr_s, rv_s, rxd_s);
  endtask
  task automatic rreg(logic [7:0] a);
    drive(1, 0, 1, a, 8'h00, tr_s, rv_s, rxd_s);
  endtask
  initial begin
    tr_s = 0; rv_s = 0; rxd_s = 8'h00;
    drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
    drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
    idle(1);
    rreg(8'd1);
    rreg(8'd3);
    wreg(8'd0, 8'hA5);
    wreg(8'd0, 8'h3C);
    rreg(8'd3);
    tr_s = 1; idle(3); tr_s = 0;
    for (int i = 0; i < 9; i++) wreg(8'd0, 8'(8'h40 + i));
    rreg(8'd1);
    rreg(8'd1);
    wreg(8'd2, 8'h01);
    for (int i = 0; i < 9; i++) drive(1, 0, 0, 8'h00, 8'h00, 0, 1, 8'(8'h11 + i));
    rreg(8'd1);
    for (int i = 0; i < 9; i++) rreg(8'd0);
    rreg(8'd1);
    rreg(8'd1);
    wreg(8'd2, 8'h04);
    drive(1, 0, 0, 8'h00, 8'h00, 0, 1, 8'h77);
    idle(1);
    rreg(8'd0);
    idle(1);
    for (int i = 0; i < 3; i++) wreg(8'd0, 8'(8'hB0 + i));
    drive(1, 1, 0, 8'd2, 8'h01, 1, 0, 8'h00);
    idle(2);
    for (int i = 0; i < 3; i++) wreg(8'd0, 8'(8'hC0 + i));
    drive(1, 1, 0, 8'd0, 8'hD0, 1, 1, 8'h55);
    drive(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h66);
    idle(1);
    rreg(8'd1);
    rreg(8'd3);
    for (int p = 0; p < 15; p++) begin
      int pw, pr, ptr, prv;
      pw = $urandom_range(90); pr = $urandom_range(90);
      ptr = $urandom_range(100); prv = $urandom_range(100);
      for (int i = 0; i < 200; i++) begin
        bit w, d;
        logic [7:0] a, wd;
        w = $urandom_range(99) < pw;
        d = $urandom_range(99) < pr;
        a = 8'($urandom_range(9));
        a = a > 8'd5 ? 8'd0 : a;
        wd = 8'($urandom);
        if (w && a == 8'd2 && $urandom_range(3) != 0) wd[1:0] = 2'b00;
        drive($urandom_range(499) != 0, w, d, a, wd,
              $urandom_range(99) < ptr, $urandom_range(99) < prv, 8'($urandom));
      end
    end
    idle(2);
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/io_mailbox.md
# io_mailbox

Port-mapped byte mailbox on the processor I/O bus: the responder for the core's port reads and writes. Core writes push into a TX FIFO drained over an external valid/ready stream; external RX stream bytes fill an RX FIFO that the core pops by reading. It also provides a status register, counts, flush control and a level interrupt, and sits between the core's port address/strobe outputs and off-core logic.

## Interface
- BASE_ADDR, 8'h00: port address of register 0. Registers occupy BASE_ADDR..BASE_ADDR+3.
- DEPTH_LOG2, 3: FIFO depth is 2^DEPTH_LOG2 per direction. Legal range 1..3, so counts fit 4 bits.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- port_addr  in  8  core I/O port address.
- wr  in  1  core write strobe, one cycle per access.
- rd  in  1  core read strobe, one cycle per access.
- wr_data  in  8  core write data.
- rd_data  out  8  read data; combinational from port_addr; 8'h00 when rd=0 or address not decoded.
- tx_data  out  8  TX FIFO head byte.
- tx_valid  out  1  TX FIFO not empty.
- tx_ready  in  1  external sink accepts.
- rx_data  in  8  external source byte.
- rx_valid  in  1  external source offers a byte.
- rx_ready  out  1  RX FIFO not full.
- irq  out  1  irq_en & (RX not empty | tx_ovf | rx_udf).

## Operation
- Register map, as offsets from BASE_ADDR:
  - 0 DATA: write pushes to TX. Read returns RX head and pops it.
  - 1 STATUS, read only: bit0 rx_avail, bit1 rx_full, bit2 tx_empty, bit3 tx_full, bit4 tx_ovf (sticky), bit5 rx_udf (sticky), bit6 irq_en, bit7 0. Reading STATUS clears both sticky bits at the clock edge.
  - 2 CTRL: write bit0 = TX flush strobe, bit1 = RX flush strobe, bit2 = irq_en (stored). Read returns {5'b0, irq_en, 2'b0}.
  - 3 COUNT, read only: {tx_count[3:0], rx_count[3:0]}.
- TX push on wr & DATA. The push is accepted only if tx_count < DEPTH at that cycle. An accepted pop in the same cycle does not free the slot. If the FIFO is full, the byte is dropped and tx_ovf is set.
- RX pop on rd & DATA & rx_count != 0. If the FIFO is empty, the read returns 8'h00, nothing is popped, and rx_udf is set.
- TX pop on tx_valid & tx_ready.
- RX push on rx_valid & rx_ready.
- Simultaneous push and pop on one FIFO: both take effect and the count is unchanged.
- Flush clears the pointers and count. Flush beats any push or pop to the same FIFO in the same cycle.
- Sticky flags: a set event in the same cycle as a STATUS read wins, so the flag stays set.
- wr and rd asserted together: each is decoded independently.
- Accesses outside the four addresses are ignored.
- Pointers wrap modulo 2^DEPTH_LOG2. Counts are DEPTH_LOG2+1 bits wide and zero-extended to 4 bits.

## Timing
- Reset, asynchronous while rst_n=0:
  - pointers and counts 0, tx_ovf=0, rx_udf=0, irq_en=0.
  - Outputs: tx_valid=0, rx_ready=1, irq=0, tx_data=8'h00 (storage not reset; tx_data is masked to 0 when empty), rd_data=8'h00.
  - Reset asserted mid-transfer discards all FIFO contents.
- Core write at edge N: tx_valid is high after edge N. Earliest external accept is at edge N+1.
- RX byte accepted at edge N: rx_avail=1 and irq (if enabled) after edge N. A DATA read in the following cycle returns that byte.
- rd_data is valid combinationally in the rd cycle. The pop and sticky clears occur at the end of that cycle.
- Full throughput: one push and one pop per cycle per FIFO.

## Structure
- Package io_mailbox_pkg holds:
  - register offsets: REG_DATA=0, REG_STATUS=1, REG_CTRL=2, REG_COUNT=3.
  - STATUS bit indices.
  - CTRL bit indices.
- Sub-module byte_fifo (params DEPTH_LOG2):
  - Inputs: clk, rst_n, push, pop, flush, din.
  - Outputs: dout, count, empty, full.
  - Instanced twice, once for TX and once for RX.
- Top level contains the address decode, sticky flags, irq_en and the read mux.

## Test plan
- Reset with DEPTH_LOG2=3: tx_valid=0, rx_ready=1, STATUS reads 8'h04, COUNT reads 8'h00.
- Write 8'hA5, 8'h3C to DATA with tx_ready=0: COUNT=8'h20, tx_data=8'hA5. Raise tx_ready: 8'hA5 then 8'h3C are emitted on consecutive edges, then tx_valid=0.
- Write 9 bytes with tx_ready=0: the 9th is dropped, STATUS=8'h18. Read STATUS again: 8'h08.
- Drive rx bytes 8'h11..8'h18 continuously: rx_ready=0 after the 8th. Eight DATA reads return 8'h11..8'h18 in order. A ninth read returns 8'h00 and sets rx_udf.
- Write CTRL=8'h04, then receive one byte: irq=1 the next cycle. A DATA read pops it and irq=0.
- With TX holding 3 bytes, write CTRL=8'h01 in the same cycle as a tx_ready handshake: tx_count=0 and tx_valid=0 afterwards. Repeat with rst_n pulsed low mid-stream: all state returns to reset values.
